// File: rtl/tacho_gate_sequencer_if.sv
// Control/status bundle between the top level, the tacho gate sequencer and
// the external pulse counter it drives.
interface tacho_gate_sequencer_if #(
    parameter int GATE_W = 12,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              stop;
    logic              mode_cont;
    logic [GATE_W-1:0] gate_ms;
    logic [HOLD_W-1:0] hold_ms;
    logic [CNT_W-1:0]  cnt_in;
    logic              cnt_ovf;
    logic              clr_cnt;
    logic              count_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  result;
    logic              result_ovf;

    modport master (
        output start, stop, mode_cont, gate_ms, hold_ms, cnt_in, cnt_ovf,
        input  clr_cnt, count_en, busy, done, result, result_ovf
    );

    modport slave (
        input  start, stop, mode_cont, gate_ms, hold_ms, cnt_in, cnt_ovf,
        output clr_cnt, count_en, busy, done, result, result_ovf
    );
endinterface

// File: rtl/tacho_gate_sequencer.sv
// Measurement-window scheduler for the tachometer: clear, gate for N ms, latch
// with saturation, optional holdoff, then repeat or return to idle.
module tacho_gate_sequencer #(
    parameter int TICKS_PER_MS = 100_000,
    parameter int GATE_W       = 12,
    parameter int HOLD_W       = 8,
    parameter int CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst,
    tacho_gate_sequencer_if.slave bus
);
    localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int MS_W  = (GATE_W > HOLD_W) ? GATE_W : HOLD_W;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, GATE, LATCH, HOLD} state_t;

    state_t            state;
    logic [PRE_W-1:0]  pre_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [GATE_W-1:0] gate_last;
    logic [HOLD_W-1:0] hold_last;
    logic              hold_zero;
    logic              ovf_sticky;

    logic              clr_cnt_r;
    logic              count_en_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  result_r;
    logic              result_ovf_r;

    logic tick_last;
    logic gate_end;
    logic hold_end;
    logic ovf_now;

    function automatic logic [CNT_W-1:0] saturate(input logic [CNT_W-1:0] cnt,
                                                  input logic ovf);
        return ovf ? {CNT_W{1'b1}} : cnt;
    endfunction

    // A zero gate length runs as a 1 ms window.
    function automatic logic [GATE_W-1:0] gate_last_of(input logic [GATE_W-1:0] ms);
        return (ms == '0) ? '0 : ms - GATE_W'(1);
    endfunction

    assign tick_last = (pre_cnt == PRE_LAST);
    assign gate_end  = tick_last && (ms_cnt == MS_W'(gate_last));
    assign hold_end  = tick_last && (ms_cnt == MS_W'(hold_last));
    assign ovf_now   = ovf_sticky | bus.cnt_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pre_cnt      <= '0;
            ms_cnt       <= '0;
            gate_last    <= '0;
            hold_last    <= '0;
            hold_zero    <= 1'b1;
            ovf_sticky   <= 1'b0;
            clr_cnt_r    <= 1'b0;
            count_en_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            result_r     <= '0;
            result_ovf_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.stop && (state == CLEAR || state == GATE || state == HOLD)) begin
                // Abort: the partial window is discarded and result is kept.
                state      <= IDLE;
                clr_cnt_r  <= 1'b0;
                count_en_r <= 1'b0;
                busy_r     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.stop) begin
                            gate_last <= gate_last_of(bus.gate_ms);
                            hold_last <= bus.hold_ms - HOLD_W'(1);
                            hold_zero <= (bus.hold_ms == '0);
                            state     <= CLEAR;
                            clr_cnt_r <= 1'b1;
                            busy_r    <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        ovf_sticky <= 1'b0;
                        pre_cnt    <= '0;
                        ms_cnt     <= '0;
                        clr_cnt_r  <= 1'b0;
                        count_en_r <= 1'b1;
                        state      <= GATE;
                    end
                    GATE: begin
                        if (bus.cnt_ovf) ovf_sticky <= 1'b1;
                        if (gate_end) begin
                            count_en_r <= 1'b0;
                            state      <= LATCH;
                        end else if (tick_last) begin
                            pre_cnt <= '0;
                            ms_cnt  <= ms_cnt + MS_W'(1);
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end
                    LATCH: begin
                        result_r     <= saturate(bus.cnt_in, ovf_now);
                        result_ovf_r <= ovf_now;
                        done_r       <= 1'b1;
                        pre_cnt      <= '0;
                        ms_cnt       <= '0;
                        if (bus.stop || !bus.mode_cont) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else if (hold_zero) begin
                            state     <= CLEAR;
                            clr_cnt_r <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (hold_end) begin
                            gate_last <= gate_last_of(bus.gate_ms);
                            hold_last <= bus.hold_ms - HOLD_W'(1);
                            hold_zero <= (bus.hold_ms == '0);
                            state     <= CLEAR;
                            clr_cnt_r <= 1'b1;
                        end else if (tick_last) begin
                            pre_cnt <= '0;
                            ms_cnt  <= ms_cnt + MS_W'(1);
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        clr_cnt_r  <= 1'b0;
                        count_en_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.clr_cnt    = clr_cnt_r;
    assign bus.count_en   = count_en_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result     = result_r;
    assign bus.result_ovf = result_ovf_r;
endmodule

// File: tb/tb_tacho_gate_sequencer.sv
// Directed bench for tacho_gate_sequencer with a 10-tick millisecond so window
// timing can be checked cycle-exactly.
module tb_tacho_gate_sequencer;
    localparam int TICKS  = 10;
    localparam int GATE_W = 12;
    localparam int HOLD_W = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tacho_gate_sequencer_if #(.GATE_W(GATE_W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) bus ();

    tacho_gate_sequencer #(
        .TICKS_PER_MS(TICKS), .GATE_W(GATE_W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Cycle index and output history, all sampled on the falling edge.
    int         cyc = 0;
    int         en_cnt = 0, clr_n = 0, done_n = 0;
    int         done_cyc = 0, en_rise = 0;
    logic       prev_en = 1'b0;
    logic [15:0] res_at_done = '0;
    logic       ovf_at_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_en <= bus.count_en;
        if (bus.count_en) en_cnt <= en_cnt + 1;
        if (bus.count_en && !prev_en) en_rise <= cyc;
        if (bus.clr_cnt) clr_n <= clr_n + 1;
        if (bus.done) begin
            done_n      <= done_n + 1;
            done_cyc    <= cyc;
            res_at_done <= bus.result;
            ovf_at_done <= bus.result_ovf;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    int s_cyc;

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && bus.busy; i++) @(negedge clk);
        check_val(tag, 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && done_n < target; i++) @(negedge clk);
        check_val(tag, 32'(done_n >= target), 32'd1);
    endtask

    int e0, c0, d0, d1cyc;
    logic [15:0] r1;

    initial begin
        bus.start = 0; bus.stop = 0; bus.mode_cont = 0;
        bus.gate_ms = 3; bus.hold_ms = 0; bus.cnt_in = 7; bus.cnt_ovf = 0;

        repeat (3) @(negedge clk);
        check_val("rst_clr",      32'(bus.clr_cnt),    0);
        check_val("rst_en",       32'(bus.count_en),   0);
        check_val("rst_busy",     32'(bus.busy),       0);
        check_val("rst_done",     32'(bus.done),       0);
        check_val("rst_result",   32'(bus.result),     0);
        check_val("rst_res_ovf",  32'(bus.result_ovf), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single shot, 3 ms gate.
        e0 = en_cnt; c0 = clr_n; d0 = done_n;
        pulse_start();
        wait_idle("ss_idle", 100);
        check_val("ss_clr_cycles",  32'(clr_n - c0),       1);
        check_val("ss_en_cycles",   32'(en_cnt - e0),      30);
        check_val("ss_en_first",    32'(en_rise - s_cyc),  2);
        check_val("ss_done_count",  32'(done_n - d0),      1);
        check_val("ss_done_time",   32'(done_cyc - s_cyc), 33);
        check_val("ss_result",      32'(res_at_done),      7);
        check_val("ss_ovf",         32'(ovf_at_done),      0);
        check_val("ss_result_hold", 32'(bus.result),       7);

        // Zero gate length runs 1 ms; mid-window gate change is ignored.
        bus.gate_ms = 0;
        e0 = en_cnt; d0 = done_n;
        pulse_start();
        repeat (4) @(negedge clk);
        bus.gate_ms = 5;
        wait_idle("g0_idle", 100);
        check_val("g0_en_cycles",  32'(en_cnt - e0), 10);
        check_val("g0_done_count", 32'(done_n - d0), 1);

        // Continuous 2 ms gate, 1 ms holdoff; stop during the second holdoff.
        bus.mode_cont = 1; bus.gate_ms = 2; bus.hold_ms = 1; bus.cnt_in = 4;
        c0 = clr_n; d0 = done_n;
        pulse_start();
        wait_done("ct_done1", d0 + 1, 100);
        @(negedge clk);
        r1 = res_at_done; d1cyc = done_cyc;
        bus.cnt_in = 9;
        wait_done("ct_done2", d0 + 2, 100);
        @(negedge clk);
        check_val("ct_result1", 32'(r1), 4);
        check_val("ct_result2", 32'(res_at_done), 9);
        check_val("ct_period",  32'(done_cyc - d1cyc), 32);
        bus.stop = 1;
        @(negedge clk);
        bus.stop = 0; bus.mode_cont = 0;
        repeat (60) @(negedge clk);
        check_val("ct_stop_busy",  32'(bus.busy),     0);
        check_val("ct_no_done3",   32'(done_n - d0),  2);
        check_val("ct_no_clr3",    32'(clr_n - c0),   2);
        check_val("ct_result_kept", 32'(bus.result),  9);

        // Overflow during the gate saturates; next clean window clears the flag.
        bus.gate_ms = 1; bus.hold_ms = 0; bus.cnt_in = 3;
        pulse_start();
        repeat (4) @(negedge clk);
        bus.cnt_ovf = 1;
        @(negedge clk);
        bus.cnt_ovf = 0;
        wait_idle("ov_idle", 100);
        check_val("ov_result", 32'(bus.result),     32'hFFFF);
        check_val("ov_flag",   32'(bus.result_ovf), 1);
        pulse_start();
        wait_idle("ov2_idle", 100);
        check_val("ov2_result", 32'(bus.result),     3);
        check_val("ov2_flag",   32'(bus.result_ovf), 0);

        // Stop beats a simultaneous start in IDLE.
        c0 = clr_n;
        @(negedge clk);
        bus.start = 1; bus.stop = 1;
        @(negedge clk);
        bus.start = 0; bus.stop = 0;
        repeat (2) @(negedge clk);
        check_val("ss_stop_busy", 32'(bus.busy),   0);
        check_val("ss_stop_clr",  32'(clr_n - c0), 0);

        // Start while gating does not restart the window.
        bus.gate_ms = 2;
        e0 = en_cnt; c0 = clr_n; d0 = done_n;
        pulse_start();
        begin
            int s_keep;
            s_keep = s_cyc;
            repeat (7) @(negedge clk);
            bus.start = 1;
            @(negedge clk);
            bus.start = 0;
            s_cyc = s_keep;
        end
        wait_idle("rs_idle", 100);
        check_val("rs_en_cycles",  32'(en_cnt - e0),      20);
        check_val("rs_clr_cycles", 32'(clr_n - c0),       1);
        check_val("rs_done_count", 32'(done_n - d0),      1);
        check_val("rs_done_time",  32'(done_cyc - s_cyc), 23);

        // Reset mid-gate aborts without a done; a following window is normal.
        bus.gate_ms = 3;
        d0 = done_n;
        pulse_start();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("ar_en",      32'(bus.count_en),   0);
        check_val("ar_result",  32'(bus.result),     0);
        check_val("ar_busy",    32'(bus.busy),       0);
        check_val("ar_res_ovf", 32'(bus.result_ovf), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_val("ar_no_done", 32'(done_n - d0), 0);
        bus.cnt_in = 5;
        e0 = en_cnt; d0 = done_n;
        pulse_start();
        wait_idle("ar2_idle", 100);
        check_val("ar2_en_cycles", 32'(en_cnt - e0),      30);
        check_val("ar2_done_time", 32'(done_cyc - s_cyc), 33);
        check_val("ar2_result",    32'(res_at_done),      5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
